// File: rtl/equiv_stim_gen.sv
// Seeded 64-bit Galois LFSR stimulus source for the equivalence-check harness.
// Vectors are presented over valid/ready; bursts are counted or free-running.
module equiv_stim_gen #(
  parameter int          CNT_W = 16,
  parameter logic [63:0] TAPS  = 64'hD800_0000_0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [63:0]      seed,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             rdy,
  output logic             vld,
  output logic [11:0]      wire0,
  output logic [9:0]       wire1,
  output logic [19:0]      wire2,
  output logic [20:0]      wire3,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [62:0]      vec_q, vec_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hs;

  assign hs = vld_q & rdy;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    vec_idx_d = vec_idx_q;
    num_vec_d = num_vec_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lfsr_d    = (seed == 64'h0) ? 64'h1 : seed;
          vec_idx_d = '0;
          num_vec_d = num_vec;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 64'h0);
          vec_idx_d = vec_idx_q + 1'b1;
          if ((num_vec_q != '0) && (vec_idx_q == num_vec_q - 1'b1))
            state_d = DONE;
        end
        if (stop)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    vld_d  = (state_d == RUN);
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    vec_d  = (state_d == IDLE) ? 63'h0 : lfsr_d[62:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= 64'h1;
      vec_idx_q <= '0;
      num_vec_q <= '0;
      vec_q     <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      vec_idx_q <= vec_idx_d;
      num_vec_q <= num_vec_d;
      vec_q     <= vec_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign vld     = vld_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vec_idx = vec_idx_q;
  assign wire0   = vec_q[11:0];
  assign wire1   = vec_q[21:12];
  assign wire2   = vec_q[41:22];
  assign wire3   = vec_q[62:42];

endmodule

// File: tb/tb_equiv_stim_gen.sv
// Directed self-checking bench for equiv_stim_gen with a reference LFSR model.
module tb_equiv_stim_gen;

  localparam int          CNT_W = 16;
  localparam logic [63:0] TAPS  = 64'hD800_0000_0000_0000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic [63:0]      seed;
  logic [CNT_W-1:0] num_vec;
  logic             rdy;
  logic             vld;
  logic [11:0]      wire0;
  logic [9:0]       wire1;
  logic [19:0]      wire2;
  logic [20:0]      wire3;
  logic [CNT_W-1:0] vec_idx;
  logic             busy;
  logic             done;

  int n_tests;
  int n_fail;

  equiv_stim_gen #(.CNT_W(CNT_W), .TAPS(TAPS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .seed    (seed),
    .num_vec (num_vec),
    .rdy     (rdy),
    .vld     (vld),
    .wire0   (wire0),
    .wire1   (wire1),
    .wire2   (wire2),
    .wire3   (wire3),
    .vec_idx (vec_idx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 64'h0);
  endfunction

  function automatic logic [63:0] out_vec();
    return {1'b0, wire3, wire2, wire1, wire0};
  endfunction

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [63:0] s, input logic [CNT_W-1:0] n);
    seed    = s;
    num_vec = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  logic [63:0] m;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    seed    = 64'h1;
    num_vec = 16'd2;
    rdy     = 1'b1;

    // Reset state
    #12;
    check("rst_vld",  {63'h0, vld},  64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_idx",  {48'h0, vec_idx}, 64'h0);
    check("rst_vec",  out_vec(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two-vector burst from seed 1
    start_burst(64'h1, 16'd2);
    check("b1_vld",   {63'h0, vld}, 64'h1);
    check("b1_busy",  {63'h0, busy}, 64'h1);
    check("b1_wire0", {52'h0, wire0}, 64'h001);
    check("b1_rest",  {1'b0, wire3, wire2, wire1, 12'h0}, 64'h0);
    check("b1_idx",   {48'h0, vec_idx}, 64'h0);
    tick();
    check("b2_wire3", {43'h0, wire3}, 64'h160000);
    check("b2_rest",  {22'h0, wire2, wire1, wire0}, 64'h0);
    check("b2_idx",   {48'h0, vec_idx}, 64'h1);
    tick();
    check("b3_vld",  {63'h0, vld},  64'h0);
    check("b3_done", {63'h0, done}, 64'h1);
    check("b3_busy", {63'h0, busy}, 64'h0);

    // Backpressure: hold rdy low for 5 cycles, then full throughput
    rdy = 1'b0;
    m   = 64'h0123_4567_89AB_CDEF;
    start_burst(m, 16'd0);
    check("bp_done_clr", {63'h0, done}, 64'h0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_vec", out_vec(), {1'b0, m[62:0]});
      check("bp_hold_idx", {48'h0, vec_idx}, 64'h0);
      tick();
    end
    rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      m = lfsr_step(m);
      check("bp_adv_vec", out_vec(), {1'b0, m[62:0]});
      check("bp_adv_idx", {48'h0, vec_idx}, 64'(i));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("bp_stop_done", {63'h0, done}, 64'h1);
    check("bp_stop_idx",  {48'h0, vec_idx}, 64'h4);

    // Zero seed behaves as seed 1
    rdy = 1'b0;
    start_burst(64'h0, 16'd1);
    check("zs_wire0", {52'h0, wire0}, 64'h001);
    check("zs_vec",   out_vec(), 64'h1);
    rdy = 1'b1;
    tick();
    check("zs_done", {63'h0, done}, 64'h1);

    // Free-run, stop in the tenth handshake; start in RUN ignored
    m = 64'hA5A5_1234_DEAD_BEEF;
    start_burst(m, 16'd0);
    for (int i = 1; i <= 9; i++) begin
      if (i == 4) begin
        seed  = 64'h5555;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      m = lfsr_step(m);
      check("fr_vec", out_vec(), {1'b0, m[62:0]});
      check("fr_idx", {48'h0, vec_idx}, 64'(i));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("fr_done", {63'h0, done}, 64'h1);
    check("fr_vld",  {63'h0, vld},  64'h0);
    check("fr_idx10", {48'h0, vec_idx}, 64'd10);

    // Replay: same seed, 100 vectors against the model
    m = 64'hA5A5_1234_DEAD_BEEF;
    start_burst(m, 16'd100);
    for (int i = 0; i < 100; i++) begin
      check("rp_vec", out_vec(), {1'b0, m[62:0]});
      check("rp_idx", {48'h0, vec_idx}, 64'(i));
      m = lfsr_step(m);
      tick();
    end
    check("rp_done", {63'h0, done}, 64'h1);
    check("rp_idx_end", {48'h0, vec_idx}, 64'd100);

    // Asynchronous reset mid-burst at vector 3
    start_burst(64'hFFFF_0000_FFFF_0000, 16'd0);
    tick();
    tick();
    tick();
    check("ar_pre_idx", {48'h0, vec_idx}, 64'h3);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_vld",  {63'h0, vld},  64'h0);
    check("ar_busy", {63'h0, busy}, 64'h0);
    check("ar_done", {63'h0, done}, 64'h0);
    check("ar_idx",  {48'h0, vec_idx}, 64'h0);
    check("ar_vec",  out_vec(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("ar_idle_vld",  {63'h0, vld},  64'h0);
    check("ar_idle_done", {63'h0, done}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
